sc_branch_unit: RTL and testbench
=================================

Name: sc_branch_unit

Overview:
- Downstream consumer of the PSR condition codes {N,Z,V,C}.
- Evaluates SPARC Bicc branch conditions against those flags and computes the branch target.
- Sequences the architectural delay slot, including annulment.
- Drives PC-source select and squash to the fetch/decode stage; keeps a saturating taken-branch counter for debug.

Parameters:
DATAWIDTH_BUS, 32, PC and target address width
DATAWIDTH_DISP, 22, branch displacement field width (word displacement)
DATAWIDTH_FLAGS, 4, condition-code width, ordered {N,Z,V,C}
DATAWIDTH_COUNT, 16, taken-branch counter width

Ports:
SC_BranchUnit_CLOCK_50  in  1  system clock, posedge
SC_BranchUnit_RESET_InLow  in  1  synchronous active-low reset
SC_BranchUnit_Stall_InHigh  in  1  freeze all state this cycle
SC_BranchUnit_Valid_InHigh  in  1  current decoded instruction is a Bicc
SC_BranchUnit_Cond  in  4  Bicc cond field
SC_BranchUnit_Annul  in  1  Bicc a-bit
SC_BranchUnit_Disp  in  DATAWIDTH_DISP  signed word displacement
SC_BranchUnit_Pc  in  DATAWIDTH_BUS  PC of the branch instruction
SC_BranchUnit_Flags  in  DATAWIDTH_FLAGS  PSR output {N,Z,V,C}
SC_BranchUnit_PcSel_Out  out  1  1 = fetch from Target_Out
SC_BranchUnit_Target_Out  out  DATAWIDTH_BUS  registered branch target
SC_BranchUnit_Squash_Out  out  1  1 = annul the instruction now in the delay slot
SC_BranchUnit_DctiErr_Out  out  1  sticky: branch seen in delay slot
SC_BranchUnit_TakenCount_Out  out  DATAWIDTH_COUNT  saturating taken count

Behaviour:
- Reset (RESET_InLow=0 at posedge): state=IDLE; taken_r=0; annul_r=0; Target=0; DctiErr=0; TakenCount=0. Reset has priority over Stall. Reset mid-DELAY aborts the pending redirect.
- Stall=1 and no reset: every register holds its value; outputs stay unchanged.

Condition decode (combinational, F={N,Z,V,C}):
- 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V.
- 0100 C|Z; 0101 C; 0110 N; 0111 V.
- 1000 always; 1001..1111 are the complements of 0001..0111 in the same order.

Target:
- Target = Pc + (sign_extend(Disp) << 2), modulo 2^DATAWIDTH_BUS. Wrap-around is ignored.

FSM, 2 states; transitions at posedge with no stall:
- IDLE, Valid=1:
  - taken_r <= cond_true; Target <= computed target.
  - annul_r <= Annul & (~cond_true | (Cond==1000)). SPARC rule: a taken BA,a also annuls its delay slot.
  - state <= DELAY.
  - If cond_true and TakenCount != all-ones, TakenCount increments.
- IDLE, Valid=0: stay in IDLE.
- DELAY: state <= IDLE unconditionally.
  - If Valid=1 here (DCTI couple): DctiErr <= 1 (sticky until reset). The branch is not evaluated, the counter is not incremented, and Target is unchanged.

Outputs (combinational from state/registers):
- PcSel_Out = (state==DELAY) & taken_r.
- Squash_Out = (state==DELAY) & annul_r.
- Both are 0 in IDLE.

Timing:
- Latency: redirect and squash are visible exactly 1 cycle after the branch is accepted, for exactly 1 unstalled cycle.
- Flags are sampled at the accepting posedge. The PSR updates on the negedge, so flags written by the instruction ahead are already visible.
- Back-to-back branches: a branch in the cycle right after acceptance is a DCTI couple. A branch two cycles later is accepted normally.

Test Plan:
- Reset then Valid=1, Cond=0001 (BE), Flags=0100, Pc=0x100, Disp=0x000004, Annul=0:
  - next cycle PcSel=1, Target=0x110, Squash=0.
  - following cycle PcSel=0.
  - TakenCount=1.
- Cond=1001 (BNE), Flags=0100, Annul=1: not taken → next cycle PcSel=0, Squash=1; TakenCount unchanged.
- Cond=1000 (BA), Annul=1, Disp=0x3FFFFF, Pc=0x200: PcSel=1, Squash=1, Target=0x1FC.
- Sweep all 16 conds × 16 flag values with Annul=0:
  - PcSel in the DELAY cycle matches the decode table (256 checks).
  - Cond=0000 is never taken; Cond=1000 is always taken.
- DCTI couple and stall:
  - Branch accepted, Valid=1 again next cycle → DctiErr=1 sticky, Target unchanged, state back to IDLE.
  - Stall=1 during DELAY holds PcSel=1 for the stalled cycles.
  - Reset during DELAY → PcSel=0, Squash=0, DctiErr=0 the next cycle.
- Counter saturation: preload via 65535 taken BAs, then one more BA → TakenCount stays 0xFFFF.

Source files
------------

// File: rtl/sc_branch_unit.sv
// sc_branch_unit: evaluates SPARC Bicc conditions against the PSR flags {N,Z,V,C},
// computes the branch target and sequences the delay slot. It drives the fetch
// redirect (PcSel/Target) and the delay-slot squash, flags DCTI couples, and keeps
// a saturating taken-branch counter for debug.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no branch pending; a valid Bicc is evaluated and accepted
// ST_DELAY | delay-slot cycle; redirect/squash presented for one cycle
module sc_branch_unit #(
  parameter int DATAWIDTH_BUS   = 32,
  parameter int DATAWIDTH_DISP  = 22,
  parameter int DATAWIDTH_FLAGS = 4,
  parameter int DATAWIDTH_COUNT = 16
) (
  input  logic                       SC_BranchUnit_CLOCK_50,
  input  logic                       SC_BranchUnit_RESET_InLow,
  input  logic                       SC_BranchUnit_Stall_InHigh,
  input  logic                       SC_BranchUnit_Valid_InHigh,
  input  logic [3:0]                 SC_BranchUnit_Cond,
  input  logic                       SC_BranchUnit_Annul,
  input  logic [DATAWIDTH_DISP-1:0]  SC_BranchUnit_Disp,
  input  logic [DATAWIDTH_BUS-1:0]   SC_BranchUnit_Pc,
  input  logic [DATAWIDTH_FLAGS-1:0] SC_BranchUnit_Flags,
  output logic                       SC_BranchUnit_PcSel_Out,
  output logic [DATAWIDTH_BUS-1:0]   SC_BranchUnit_Target_Out,
  output logic                       SC_BranchUnit_Squash_Out,
  output logic                       SC_BranchUnit_DctiErr_Out,
  output logic [DATAWIDTH_COUNT-1:0] SC_BranchUnit_TakenCount_Out
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DELAY = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic                       taken_q, taken_d;
  logic                       annul_q, annul_d;
  logic [DATAWIDTH_BUS-1:0]   target_q, target_d;
  logic                       dcti_err_q, dcti_err_d;
  logic [DATAWIDTH_COUNT-1:0] count_q, count_d;

  logic                       flag_n, flag_z, flag_v, flag_c;
  logic                       base_true;
  logic                       cond_true;
  logic [DATAWIDTH_BUS-1:0]   disp_ext;
  logic [DATAWIDTH_BUS-1:0]   target_calc;

  assign flag_n = SC_BranchUnit_Flags[3];
  assign flag_z = SC_BranchUnit_Flags[2];
  assign flag_v = SC_BranchUnit_Flags[1];
  assign flag_c = SC_BranchUnit_Flags[0];

  // Condition decode: cond[3] inverts the base test, so 1000 (always) is the
  // complement of 0000 (never).
  always_comb begin
    base_true = 1'b0;
    case (SC_BranchUnit_Cond[2:0])
      3'b000:  base_true = 1'b0;
      3'b001:  base_true = flag_z;
      3'b010:  base_true = flag_z | (flag_n ^ flag_v);
      3'b011:  base_true = flag_n ^ flag_v;
      3'b100:  base_true = flag_c | flag_z;
      3'b101:  base_true = flag_c;
      3'b110:  base_true = flag_n;
      3'b111:  base_true = flag_v;
      default: base_true = 1'b0;
    endcase
    cond_true = SC_BranchUnit_Cond[3] ? ~base_true : base_true;
  end

  // Word displacement, sign-extended and scaled to bytes; overflow wraps.
  assign disp_ext    = {{(DATAWIDTH_BUS-DATAWIDTH_DISP){SC_BranchUnit_Disp[DATAWIDTH_DISP-1]}},
                        SC_BranchUnit_Disp};
  assign target_calc = SC_BranchUnit_Pc + (disp_ext << 2);

  // Next-state logic; every register holds by default, which also implements stall.
  always_comb begin
    state_d    = state_q;
    taken_d    = taken_q;
    annul_d    = annul_q;
    target_d   = target_q;
    dcti_err_d = dcti_err_q;
    count_d    = count_q;
    if (!SC_BranchUnit_Stall_InHigh) begin
      case (state_q)
        ST_IDLE: begin
          if (SC_BranchUnit_Valid_InHigh) begin
            taken_d  = cond_true;
            target_d = target_calc;
            // A taken BA,a annuls its delay slot as well as an untaken branch,a.
            annul_d  = SC_BranchUnit_Annul &
                       (~cond_true | (SC_BranchUnit_Cond == 4'b1000));
            state_d  = ST_DELAY;
            if (cond_true && (count_q != {DATAWIDTH_COUNT{1'b1}})) begin
              count_d = count_q + DATAWIDTH_COUNT'(1);
            end
          end
        end
        ST_DELAY: begin
          state_d = ST_IDLE;
          // A branch in the delay slot is a DCTI couple: record it, don't evaluate it.
          if (SC_BranchUnit_Valid_InHigh) begin
            dcti_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset taking priority over stall.
  always_ff @(posedge SC_BranchUnit_CLOCK_50) begin
    if (!SC_BranchUnit_RESET_InLow) begin
      state_q    <= ST_IDLE;
      taken_q    <= 1'b0;
      annul_q    <= 1'b0;
      target_q   <= '0;
      dcti_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      taken_q    <= taken_d;
      annul_q    <= annul_d;
      target_q   <= target_d;
      dcti_err_q <= dcti_err_d;
      count_q    <= count_d;
    end
  end

  assign SC_BranchUnit_PcSel_Out      = (state_q == ST_DELAY) & taken_q;
  assign SC_BranchUnit_Squash_Out     = (state_q == ST_DELAY) & annul_q;
  assign SC_BranchUnit_Target_Out     = target_q;
  assign SC_BranchUnit_DctiErr_Out    = dcti_err_q;
  assign SC_BranchUnit_TakenCount_Out = count_q;

endmodule

// File: tb/tb_sc_branch_unit.sv
// Testbench for sc_branch_unit. A second instance with a narrow counter shares
// the same stimulus so counter saturation can be reached in a short run.
module tb_sc_branch_unit;

  localparam int SAT_W   = 5;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        valid;
  logic [3:0]  cond;
  logic        annul;
  logic [21:0] disp;
  logic [31:0] pc;
  logic [3:0]  flags;

  logic        pcsel, squash, dcti;
  logic [31:0] target;
  logic [15:0] count;

  logic             s_pcsel, s_squash, s_dcti;
  logic [31:0]      s_target;
  logic [SAT_W-1:0] s_count;

  typedef struct packed {
    logic        pcsel;
    logic        squash;
    logic [31:0] target;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_exp = '0;
  int          sat_exp = 0;

  sc_branch_unit dut (
    .SC_BranchUnit_CLOCK_50      (clk),
    .SC_BranchUnit_RESET_InLow   (rst_n),
    .SC_BranchUnit_Stall_InHigh  (stall),
    .SC_BranchUnit_Valid_InHigh  (valid),
    .SC_BranchUnit_Cond          (cond),
    .SC_BranchUnit_Annul         (annul),
    .SC_BranchUnit_Disp          (disp),
    .SC_BranchUnit_Pc            (pc),
    .SC_BranchUnit_Flags         (flags),
    .SC_BranchUnit_PcSel_Out     (pcsel),
    .SC_BranchUnit_Target_Out    (target),
    .SC_BranchUnit_Squash_Out    (squash),
    .SC_BranchUnit_DctiErr_Out   (dcti),
    .SC_BranchUnit_TakenCount_Out(count)
  );

  sc_branch_unit #(.DATAWIDTH_COUNT(SAT_W)) dut_sat (
    .SC_BranchUnit_CLOCK_50      (clk),
    .SC_BranchUnit_RESET_InLow   (rst_n),
    .SC_BranchUnit_Stall_InHigh  (stall),
    .SC_BranchUnit_Valid_InHigh  (valid),
    .SC_BranchUnit_Cond          (cond),
    .SC_BranchUnit_Annul         (annul),
    .SC_BranchUnit_Disp          (disp),
    .SC_BranchUnit_Pc            (pc),
    .SC_BranchUnit_Flags         (flags),
    .SC_BranchUnit_PcSel_Out     (s_pcsel),
    .SC_BranchUnit_Target_Out    (s_target),
    .SC_BranchUnit_Squash_Out    (s_squash),
    .SC_BranchUnit_DctiErr_Out   (s_dcti),
    .SC_BranchUnit_TakenCount_Out(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written out per cond value, F = {N,Z,V,C}.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'h0: return 1'b0;
      4'h1: return z;
      4'h2: return z | (n ^ v);
      4'h3: return n ^ v;
      4'h4: return cy | z;
      4'h5: return cy;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1'b1;
      4'h9: return !z;
      4'hA: return !(z | (n ^ v));
      4'hB: return !(n ^ v);
      4'hC: return !(cy | z);
      4'hD: return !cy;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  // Issue one Bicc at a negedge, then compare the DELAY-cycle outputs against
  // the scoreboard entry; optional stall cycles must hold the outputs.
  task automatic branch(input logic [3:0] c, input logic a, input logic [21:0] d,
                        input logic [31:0] p, input logic [3:0] f, input int stall_n);
    exp_t        e;
    logic        t;
    logic [31:0] ext;
    @(negedge clk);
    valid = 1'b1; cond = c; annul = a; disp = d; pc = p; flags = f;
    t        = cond_model(c, f);
    ext      = {{10{d[21]}}, d};
    e.pcsel  = t;
    e.squash = a & (!t | (c == 4'b1000));
    e.target = p + (ext << 2);
    sb_q.push_back(e);
    if (t && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
    if (t && sat_exp < SAT_MAX) sat_exp++;
    @(negedge clk);
    valid = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("pcsel c=%h f=%h", c, f), {31'd0, pcsel}, {31'd0, e.pcsel});
    check($sformatf("squash c=%h f=%h", c, f), {31'd0, squash}, {31'd0, e.squash});
    check("target", target, e.target);
    check("count", {16'd0, count}, {16'd0, cnt_exp});
    check("sat_count", {27'd0, s_count}, sat_exp);
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(negedge clk);
      check("stall_pcsel", {31'd0, pcsel}, {31'd0, e.pcsel});
      check("stall_squash", {31'd0, squash}, {31'd0, e.squash});
    end
    stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; valid = 1'b0; cond = '0; annul = 1'b0;
    disp = '0; pc = '0; flags = '0;
    repeat (2) @(negedge clk);
    check("rst_pcsel", {31'd0, pcsel}, 32'd0);
    check("rst_squash", {31'd0, squash}, 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_dcti", {31'd0, dcti}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    rst_n = 1'b1;

    // BE taken, no annul
    branch(4'b0001, 1'b0, 22'h000004, 32'h100, 4'b0100, 0);
    check("be_target", target, 32'h110);
    @(negedge clk);
    check("be_after_pcsel", {31'd0, pcsel}, 32'd0);
    check("be_count", {16'd0, count}, 32'd1);

    // BNE,a not taken: squash only
    branch(4'b1001, 1'b1, 22'h000004, 32'h300, 4'b0100, 0);
    check("bne_count", {16'd0, count}, 32'd1);

    // BA,a with negative displacement
    branch(4'b1000, 1'b1, 22'h3FFFFF, 32'h200, 4'b0000, 0);
    check("ba_target", target, 32'h1FC);

    // DCTI couple: second branch in the delay slot
    branch(4'b0001, 1'b0, 22'h000008, 32'h400, 4'b0100, 0);
    valid = 1'b1; cond = 4'b1000; pc = 32'h900; disp = 22'h10;
    @(negedge clk);
    valid = 1'b0;
    check("dcti_set", {31'd0, dcti}, 32'd1);
    check("dcti_pcsel", {31'd0, pcsel}, 32'd0);
    check("dcti_target", target, 32'h420);
    check("dcti_count", {16'd0, count}, {16'd0, cnt_exp});
    branch(4'b1000, 1'b0, 22'h000001, 32'h1000, 4'b0000, 0);
    check("dcti_sticky", {31'd0, dcti}, 32'd1);

    // Stall during DELAY holds the redirect
    branch(4'b0110, 1'b0, 22'h000002, 32'h2000, 4'b1000, 3);
    @(negedge clk);
    check("stall_release_pcsel", {31'd0, pcsel}, 32'd0);

    // Reset during DELAY aborts the redirect and clears everything
    branch(4'b1000, 1'b1, 22'h000001, 32'h10, 4'b0000, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstdly_pcsel", {31'd0, pcsel}, 32'd0);
    check("rstdly_squash", {31'd0, squash}, 32'd0);
    check("rstdly_dcti", {31'd0, dcti}, 32'd0);
    check("rstdly_count", {16'd0, count}, 32'd0);
    cnt_exp = '0;
    sat_exp = 0;
    rst_n = 1'b1;

    // Saturation on the narrow-counter instance: one more BA past all-ones
    for (int i = 0; i < SAT_MAX + 1; i++) begin
      branch(4'b1000, 1'b0, 22'h000001, 32'h40, 4'b0000, 0);
    end
    check("sat_hold", {27'd0, s_count}, SAT_MAX);
    check("sat_main_count", {16'd0, count}, SAT_MAX + 1);

    // Full cond x flags sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        branch(4'(c), 1'b0, 22'(c * 16 + f), 32'h8000 + 32'(f * 4), 4'(f), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
